access_sweeper: RTL and testbench

Synthesisable, parametrised address-stream generator that drives the cache/memory block through a request/response handshake and keeps hit/miss statistics in hardware. It replaces the free-running address increment and external miss tallying used in simulation. It adds programmable base, stride, access count and a write-then-read mode, so the same sweep can run in simulation, on FPGA, or as a built-in self-test driver in front of `memory_block`.

---
 rtl/sweeper_pkg.sv | 26 ++
 rtl/sat_counter.sv | 42 ++++
 rtl/access_sweeper.sv | 158 +++++++++++++++
 tb/tb_access_sweeper.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweeper_pkg.sv
// Shared types and constants for the access sweeper and its counters.
`default_nettype none

package sweeper_pkg;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        STRIDE = 2'd1,
        WR_RD  = 2'd2,
        RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Widest counter supported; narrower counters take the low bits as their ceiling.
    localparam int unsigned MAX_CNT_W = 32;
    localparam logic [MAX_CNT_W-1:0] SAT_LIMIT = '1;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
`default_nettype none

module sat_counter
    import sweeper_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] SAT_MAX = SAT_LIMIT[W-1:0];

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != SAT_MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/access_sweeper.sv
// Programmable address-sweep request generator with hit/miss statistics.
`default_nettype none

module access_sweeper
    import sweeper_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  length,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_write,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              resp_valid,
    input  logic              resp_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  access_count,
    output logic [CNT_W-1:0]  miss_count
);

    state_t            state_q;
    mode_t             mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  length_q;
    logic [CNT_W-1:0]  remain_q;
    logic              req_valid_q;
    logic              req_write_q;
    logic              busy_q;
    logic              done_q;

    logic              start_ok;
    logic              resp_ok;
    logic [ADDR_W-1:0] addr_step;
    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  remain_d;

    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign resp_ok   = resp_valid && (state_q == WAIT);
    // Reserved mode falls back to unit-step sequential sweeping.
    assign addr_step = ((mode_q == STRIDE) || (mode_q == WR_RD)) ? stride_q : ADDR_W'(1);
    assign addr_d    = addr_q + addr_step;
    assign remain_d  = remain_q - CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mode_q      <= SEQ;
            base_q      <= '0;
            stride_q    <= '0;
            addr_q      <= '0;
            length_q    <= '0;
            remain_q    <= '0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mode_q      <= mode_t'(mode);
                        base_q      <= base_addr;
                        stride_q    <= stride;
                        length_q    <= length;
                        addr_q      <= base_addr;
                        remain_q    <= length;
                        req_write_q <= (mode_t'(mode) == WR_RD);
                        if (length == '0) begin
                            state_q     <= DONE;
                            req_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            req_valid_q <= 1'b1;
                            busy_q      <= 1'b1;
                            done_q      <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (req_ready) begin
                        state_q     <= WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (resp_valid) begin
                        addr_q   <= addr_d;
                        remain_q <= remain_d;
                        if (remain_d == '0) begin
                            // The write pass of WR_RD rewinds for its read-back pass.
                            if (req_write_q) begin
                                addr_q      <= base_q;
                                remain_q    <= length_q;
                                req_write_q <= 1'b0;
                                req_valid_q <= 1'b1;
                                state_q     <= ISSUE;
                            end else begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            state_q     <= ISSUE;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_access_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .clr_i   (start_ok),
        .inc_i   (resp_ok),
        .count_o (access_count)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_miss_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .clr_i   (start_ok),
        .inc_i   (resp_ok && !resp_hit),
        .count_o (miss_count)
    );

    assign req_valid = req_valid_q;
    assign req_addr  = addr_q;
    assign req_write = req_write_q;
    assign req_wdata = DATA_W'(addr_q);
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_access_sweeper.sv
// Directed bench for access_sweeper with an address/counter model checked every cycle.
`default_nettype none

module tb_access_sweeper;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 4;
    localparam int MAX_L   = 65535;
    localparam int MAX_S   = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic [CNT_W-1:0]  length;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_hit;

    logic              req_valid,  req_valid_s;
    logic [ADDR_W-1:0] req_addr,   req_addr_s;
    logic              req_write,  req_write_s;
    logic [DATA_W-1:0] req_wdata,  req_wdata_s;
    logic              busy,       busy_s;
    logic              done,       done_s;
    logic [CNT_W-1:0]  access_count, miss_count;
    logic [CNT_W_S-1:0] acc_s, miss_s;

    int n_pass  = 0;
    int n_total = 0;

    logic [ADDR_W-1:0] exp_addr = '0;
    logic              exp_wr   = 1'b0;
    int                exp_acc = 0, exp_miss = 0, exp_acc_s = 0, exp_miss_s = 0;
    bit                cmp_en = 1'b0;

    logic [ADDR_W-1:0] seen_addr[$];
    logic              seen_wr[$];

    access_sweeper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .stride(stride), .length(length), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_hit(resp_hit), .busy(busy), .done(done),
        .access_count(access_count), .miss_count(miss_count)
    );

    access_sweeper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W_S)) dut_s (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .stride(stride), .length(length[CNT_W_S-1:0]), .req_valid(req_valid_s),
        .req_ready(req_ready), .req_addr(req_addr_s), .req_write(req_write_s),
        .req_wdata(req_wdata_s), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .busy(busy_s), .done(done_s), .access_count(acc_s), .miss_count(miss_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act !== expv) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous comparison against the model on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("access_count", 64'(access_count), 64'(exp_acc));
            check("miss_count",   64'(miss_count),   64'(exp_miss));
            check("access_count_sat", 64'(acc_s),    64'(exp_acc_s));
            check("miss_count_sat",   64'(miss_s),   64'(exp_miss_s));
            if (req_valid) begin
                check("req_addr",  64'(req_addr),  64'(exp_addr));
                check("req_write", 64'(req_write), 64'(exp_wr));
                check("req_wdata", 64'(req_wdata), 64'(exp_addr));
            end
            if (req_valid_s) begin
                check("req_addr_s",  64'(req_addr_s),  64'(exp_addr));
                check("req_write_s", 64'(req_write_s), 64'(exp_wr));
                check("req_wdata_s", 64'(req_wdata_s), 64'(exp_addr));
            end
        end
    end

    task automatic check_outs(input string name, input logic v, input logic b, input logic d);
        check({name, "_req_valid"}, 64'(req_valid), 64'(v));
        check({name, "_busy"},      64'(busy),      64'(b));
        check({name, "_done"},      64'(done),      64'(d));
        check({name, "_req_valid_s"}, 64'(req_valid_s), 64'(v));
        check({name, "_busy_s"},      64'(busy_s),      64'(b));
        check({name, "_done_s"},      64'(done_s),      64'(d));
    endtask

    // hit_mode: 0 alternate (hit first), 1 all miss, 2 all hit.
    // poke: pulse resp_valid in ISSUE and start in WAIT; abort_at: reset during WAIT of that access.
    task automatic run_sweep(input logic [1:0] m, input logic [ADDR_W-1:0] base,
                             input logic [ADDR_W-1:0] strd, input logic [CNT_W-1:0] len,
                             input int hit_mode, input int ready_delay, input bit poke,
                             input int abort_at);
        logic [ADDR_W-1:0] q_addr[$];
        logic              q_wr[$];
        logic [ADDR_W-1:0] inc, a, held;
        logic              hit;
        int                passes;
        inc    = (m == 2'd1 || m == 2'd2) ? strd : ADDR_W'(1);
        passes = (m == 2'd2) ? 2 : 1;
        for (int p = 0; p < passes; p++) begin
            a = base;
            for (int i = 0; i < int'(len); i++) begin
                q_addr.push_back(a);
                q_wr.push_back(m == 2'd2 && p == 0);
                a = a + inc;
            end
        end
        seen_addr.delete();
        seen_wr.delete();

        mode = m; base_addr = base; stride = strd; length = len; start = 1'b1;
        tick();
        start = 1'b0;
        exp_acc = 0; exp_miss = 0; exp_acc_s = 0; exp_miss_s = 0;
        if (len == '0) check_outs("len0", 1'b0, 1'b0, 1'b1);
        else           check_outs("start", 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < q_addr.size(); k++) begin
            exp_addr = q_addr[k];
            exp_wr   = q_wr[k];
            if (k == 0 && ready_delay > 0) begin
                req_ready = 1'b0;
                held = req_addr;
                for (int d = 0; d < ready_delay; d++) begin
                    if (poke && d == 1) begin
                        resp_valid = 1'b1;
                        resp_hit   = 1'b0;
                    end
                    tick();
                    resp_valid = 1'b0;
                    check("bp_req_valid", 64'(req_valid), 64'(1));
                    check("bp_req_addr",  64'(req_addr),  64'(held));
                end
            end
            seen_addr.push_back(req_addr);
            seen_wr.push_back(req_write);
            req_ready = 1'b1;
            tick();
            req_ready = 1'b0;
            check_outs("wait", 1'b0, 1'b1, 1'b0);

            if (k == abort_at) begin
                #2;
                rst = 1'b0;
                exp_acc = 0; exp_miss = 0; exp_acc_s = 0; exp_miss_s = 0;
                #1;
                check_outs("async_rst", 1'b0, 1'b0, 1'b0);
                check("async_rst_addr",  64'(req_addr),  64'(0));
                check("async_rst_wdata", 64'(req_wdata), 64'(0));
                check("async_rst_write", 64'(req_write), 64'(0));
                tick();
                rst = 1'b1;
                resp_valid = 1'b1;
                resp_hit   = 1'b0;
                tick();
                resp_valid = 1'b0;
                check_outs("late_resp", 1'b0, 1'b0, 1'b0);
                check("late_resp_acc", 64'(access_count), 64'(0));
                return;
            end

            if (poke && k == 0) begin
                start = 1'b1;
                base_addr = base + ADDR_W'(100);
                tick();
                start = 1'b0;
                base_addr = base;
                check_outs("start_in_wait", 1'b0, 1'b1, 1'b0);
            end

            case (hit_mode)
                0:       hit = (k % 2 == 0);
                1:       hit = 1'b0;
                default: hit = 1'b1;
            endcase
            resp_valid = 1'b1;
            resp_hit   = hit;
            tick();
            resp_valid = 1'b0;
            if (exp_acc < MAX_L) exp_acc++;
            if (exp_acc_s < MAX_S) exp_acc_s++;
            if (!hit) begin
                if (exp_miss < MAX_L) exp_miss++;
                if (exp_miss_s < MAX_S) exp_miss_s++;
            end
            if (k < q_addr.size() - 1) check_outs("reissue", 1'b1, 1'b1, 1'b0);
        end
        check_outs("end", 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check_outs("held", 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mode = 2'd0; base_addr = '0; stride = '0; length = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0;
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        check("reset_addr",  64'(req_addr),     64'(0));
        check("reset_acc",   64'(access_count), 64'(0));
        check("reset_miss",  64'(miss_count),   64'(0));
        tick();
        rst = 1'b1;
        cmp_en = 1'b1;

        // SEQ sweep, alternating hit/miss
        run_sweep(2'd0, 15'd1024, 15'd0, 16'd8, 0, 0, 1'b0, -1);
        check("seq_acc",   64'(access_count), 64'(8));
        check("seq_miss",  64'(miss_count),   64'(4));
        check("seq_first", 64'(seen_addr[0]), 64'(1024));
        check("seq_last",  64'(seen_addr[7]), 64'(1031));
        check("seq_read",  64'(seen_wr[3]),   64'(0));

        // STRIDE wrapping past the top of the address space
        run_sweep(2'd1, 15'h7FFC, 15'd4, 16'd3, 2, 0, 1'b0, -1);
        check("wrap_a0", 64'(seen_addr[0]), 64'(15'h7FFC));
        check("wrap_a1", 64'(seen_addr[1]), 64'(15'h0000));
        check("wrap_a2", 64'(seen_addr[2]), 64'(15'h0004));

        // WR_RD: writes then read-back
        run_sweep(2'd2, 15'd16, 15'd2, 16'd3, 2, 0, 1'b0, -1);
        check("wrrd_acc", 64'(access_count), 64'(6));
        for (int i = 0; i < 6; i++) begin
            check("wrrd_addr", 64'(seen_addr[i]), 64'(16 + 2 * (i % 3)));
            check("wrrd_wr",   64'(seen_wr[i]),   64'(i < 3));
        end

        // Backpressure, resp_valid in ISSUE, start in WAIT
        run_sweep(2'd0, 15'd100, 15'd0, 16'd2, 2, 5, 1'b1, -1);
        check("bp_acc",   64'(access_count), 64'(2));
        check("bp_miss",  64'(miss_count),   64'(0));
        check("bp_addr1", 64'(seen_addr[1]), 64'(101));

        // Zero length
        run_sweep(2'd0, 15'd50, 15'd0, 16'd0, 2, 0, 1'b0, -1);
        check("len0_acc", 64'(access_count), 64'(0));

        // Saturation: 20 misses into a 4-bit and a 16-bit counter
        run_sweep(2'd2, 15'd200, 15'd1, 16'd10, 1, 0, 1'b0, -1);
        check("sat_acc16",  64'(access_count), 64'(20));
        check("sat_miss16", 64'(miss_count),   64'(20));
        check("sat_acc4",   64'(acc_s),        64'(15));
        check("sat_miss4",  64'(miss_s),       64'(15));

        // Reset mid-run, then a clean run
        run_sweep(2'd0, 15'd300, 15'd0, 16'd10, 0, 0, 1'b0, 2);
        run_sweep(2'd0, 15'd300, 15'd0, 16'd3, 1, 0, 1'b0, -1);
        check("post_rst_acc",  64'(access_count), 64'(3));
        check("post_rst_miss", 64'(miss_count),   64'(3));
        check("post_rst_a0",   64'(seen_addr[0]), 64'(300));

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
